// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared types and default sizes for the dual-clock FIFO and its read-side drain engine
//   rd_state_t  : read-engine state (RUN, FLUSH)
//   DSIZE_DEF   : default data word width
//   ASIZE_DEF   : default FIFO address width
package async_fifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rd_state_t;

endpackage

// File: rtl/stream_skid2.sv
// rtl/stream_skid2.sv - two-entry output buffer with push/pop/clear
//   clk, rst : clock and synchronous active-high reset
//   push     : write din into the next free slot
//   pop      : retire the head entry
//   clear    : drop all entries (takes priority over push/pop)
//   din      : write data
//   head     : oldest entry, valid while count != 0
//   count    : number of stored entries, 0..2
module stream_skid2 #(
    parameter int DSIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [DSIZE-1:0] din,
    output logic [DSIZE-1:0] head,
    output logic [1:0]       count
);

    logic [DSIZE-1:0] tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else if (clear) begin
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    // A pop with nothing stored is ignored.
                    if (push) begin
                        head  <= din;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    // Simultaneous push and pop replaces the head directly,
                    // sustaining one word per cycle without using the tail.
                    if (push && pop) begin
                        head <= din;
                    end else if (push) begin
                        tail  <= din;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head <= tail;
                        if (push) begin
                            tail <= din;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - read-side drain engine turning FIFO reads into a framed valid/ready stream
//   r_clk, r_rst     : read clock and synchronous active-high reset
//   r_empty, r_data  : FIFO empty flag and asynchronous read data
//   r_en             : FIFO read strobe
//   m_valid, m_ready : stream handshake
//   m_data, m_last   : stream payload and end-of-packet marker
//   cfg_len          : packet length in beats (0 behaves as 1)
//   flush            : request to discard buffered data and drain the FIFO
//   flush_done       : one-cycle pulse when the drain completes
//   rd_count         : wrapping count of accepted beats
//   busy             : buffer holds data or a flush is in progress
module fifo_rd_stream
    import async_fifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int LSIZE = 8,
    parameter int CSIZE = 16
) (
    input  logic             r_clk,
    input  logic             r_rst,
    input  logic             r_empty,
    input  logic [DSIZE-1:0] r_data,
    output logic             r_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_last,
    input  logic [LSIZE-1:0] cfg_len,
    input  logic             flush,
    output logic             flush_done,
    output logic [CSIZE-1:0] rd_count,
    output logic             busy
);

    rd_state_t        state;
    logic [1:0]       count;
    logic [LSIZE-1:0] beat_cnt;
    logic [LSIZE-1:0] len_q;
    logic [LSIZE-1:0] len_live;
    logic [LSIZE-1:0] len_eff;
    logic             push;
    logic             pop;
    logic             clear;

    // Fetch depends only on registered state and r_empty, never on m_ready,
    // so the stream side has no combinational reach into the FIFO.
    assign r_en  = !r_empty && ((state == FLUSH) || (count != 2'd2));
    assign push  = (state == RUN) && r_en;
    assign clear = (state == RUN) && flush;

    assign m_valid = (state == RUN) && (count != 2'd0);
    assign pop     = m_valid && m_ready;
    assign busy    = (count != 2'd0) || (state == FLUSH);

    // The first beat of a packet frames itself with the live length, since
    // len_q is only loaded when that beat is accepted.
    assign len_live = (cfg_len == '0) ? LSIZE'(1) : cfg_len;
    assign len_eff  = (beat_cnt == '0) ? len_live : len_q;
    assign m_last   = m_valid && (beat_cnt == (len_eff - LSIZE'(1)));

    stream_skid2 #(
        .DSIZE (DSIZE)
    ) u_skid (
        .clk   (r_clk),
        .rst   (r_rst),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (r_data),
        .head  (m_data),
        .count (count)
    );

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state      <= RUN;
            beat_cnt   <= '0;
            len_q      <= LSIZE'(1);
            flush_done <= 1'b0;
            rd_count   <= '0;
        end else begin
            flush_done <= 1'b0;
            if (pop) begin
                rd_count <= rd_count + CSIZE'(1);
            end
            case (state)
                RUN: begin
                    if (flush) begin
                        state    <= FLUSH;
                        beat_cnt <= '0;
                    end else if (pop) begin
                        if (beat_cnt == '0) begin
                            len_q <= len_live;
                        end
                        beat_cnt <= m_last ? '0 : beat_cnt + LSIZE'(1);
                    end
                end
                default: begin
                    // Stay while more flush requests arrive or data remains.
                    if (r_empty && !flush) begin
                        state      <= RUN;
                        flush_done <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - scoreboard bench for fifo_rd_stream
module tb_fifo_rd_stream;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        r_rst;
    logic        r_empty = 1'b1;
    logic [7:0]  r_data = 8'h00;
    logic        r_en;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic [7:0]  cfg_len;
    logic        flush;
    logic        flush_done;
    logic [15:0] rd_count;
    logic        busy;

    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int en_cnt = 0;
    int fd_cnt = 0;
    int underflow_err = 0;
    int hold_err = 0;
    int first_acc = -1;
    int last_acc = -1;

    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic       pfl = 1'b0;
    logic       prst = 1'b1;
    logic [7:0] pd = 8'h00;

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .DSIZE (8),
        .LSIZE (8),
        .CSIZE (16)
    ) dut (
        .r_clk      (clk),
        .r_rst      (r_rst),
        .r_empty    (r_empty),
        .r_data     (r_data),
        .r_en       (r_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .cfg_len    (cfg_len),
        .flush      (flush),
        .flush_done (flush_done),
        .rd_count   (rd_count),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    // FIFO model: asynchronous read data presented from registered copies so the
    // DUT samples a stable value at the consuming edge.
    always @(posedge clk) begin
        if (r_en && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
        end
        r_empty <= (fifo_q.size() == 0);
        r_data  <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end

    // Monitor: pops the scoreboard on every accepted beat.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (r_en && r_empty) underflow_err++;
        if (r_en) en_cnt++;
        if (flush_done) fd_cnt++;
        if (pv && !pr && !pfl && !prst && (m_valid !== 1'b1 || m_data !== pd)) hold_err++;
        pv   = m_valid;
        pr   = m_ready;
        pd   = m_data;
        pfl  = flush;
        prst = r_rst;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_beat: got data %0h with nothing expected", m_data);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", m_data, e.data);
                chk("beat_last", m_last, e.last);
            end
        end
    end

    initial begin
        int idle_bad;
        r_rst   = 1'b1;
        m_ready = 1'b0;
        flush   = 1'b0;
        cfg_len = 8'd16;
        repeat (3) step();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_r_en", r_en, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_busy", busy, 0);
        r_rst = 1'b0;

        // Idle with an empty FIFO.
        idle_bad = 0;
        en_cnt = 0;
        repeat (20) begin
            step();
            if (m_valid !== 1'b0 || r_en !== 1'b0 || busy !== 1'b0) idle_bad++;
        end
        chk("idle_quiet", idle_bad, 0);
        chk("idle_no_read", en_cnt, 0);
        chk("idle_rd_count", rd_count, 0);

        // Streaming 0x01..0x10 at full rate, one 16-beat packet.
        first_acc = -1;
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            fifo_q.push_back(8'(i));
            push_exp(8'(i), i == 16);
        end
        wait_drain();
        chk("stream_back_to_back", last_acc - first_acc, 15);
        repeat (2) step();
        chk("stream_rd_count", rd_count, 16);
        chk("stream_busy_idle", busy, 0);

        // Backpressure: buffer fills with two words then fetch stalls.
        m_ready = 1'b0;
        cfg_len = 8'd6;
        en_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            fifo_q.push_back(8'hA0 + 8'(i));
            push_exp(8'hA0 + 8'(i), i == 5);
        end
        repeat (10) step();
        chk("bp_fetch_count", en_cnt, 2);
        chk("bp_m_valid", m_valid, 1);
        chk("bp_m_data", m_data, 8'hA0);
        chk("bp_busy", busy, 1);
        m_ready = 1'b1;
        wait_drain();
        repeat (2) step();
        chk("bp_rd_count", rd_count, 22);

        // Framing: length 3, then length 0 (treated as 1) mid-packet.
        cfg_len = 8'd3;
        for (int i = 0; i < 7; i++) begin
            fifo_q.push_back(8'h30 + 8'(i));
            push_exp(8'h30 + 8'(i), (i == 2) || (i == 5));
        end
        wait_drain();
        repeat (2) step();
        cfg_len = 8'd0;
        fifo_q.push_back(8'h37); push_exp(8'h37, 1'b0);
        fifo_q.push_back(8'h38); push_exp(8'h38, 1'b1);
        fifo_q.push_back(8'h39); push_exp(8'h39, 1'b1);
        fifo_q.push_back(8'h3A); push_exp(8'h3A, 1'b1);
        wait_drain();
        repeat (2) step();
        chk("frame_rd_count", rd_count, 33);

        // Leave the beat counter mid-packet before flushing.
        cfg_len = 8'd4;
        fifo_q.push_back(8'h60); push_exp(8'h60, 1'b0);
        wait_drain();
        repeat (2) step();

        // Flush: two words buffered, five still in the FIFO.
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) fifo_q.push_back(8'h70 + 8'(i));
        repeat (5) step();
        chk("fl_pre_fifo_left", fifo_q.size(), 5);
        chk("fl_pre_m_valid", m_valid, 1);
        fd_cnt = 0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_m_valid_drop", m_valid, 0);
        chk("fl_busy", busy, 1);
        repeat (12) step();
        chk("fl_done_pulses", fd_cnt, 1);
        chk("fl_fifo_drained", fifo_q.size(), 0);
        chk("fl_busy_after", busy, 0);
        chk("fl_rd_count", rd_count, 34);
        m_ready = 1'b1;
        cfg_len = 8'd2;
        fifo_q.push_back(8'h80); push_exp(8'h80, 1'b0);
        fifo_q.push_back(8'h81); push_exp(8'h81, 1'b1);
        fifo_q.push_back(8'h82); push_exp(8'h82, 1'b0);
        wait_drain();
        repeat (2) step();
        chk("post_flush_rd_count", rd_count, 37);

        // Reset mid-packet with the buffer full.
        m_ready = 1'b0;
        cfg_len = 8'd3;
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'h90 + 8'(i));
        repeat (5) step();
        chk("mid_rst_buffered", m_valid, 1);
        r_rst = 1'b1;
        fifo_q.delete();
        repeat (2) step();
        r_rst = 1'b0;
        step();
        chk("mid_rst_rd_count", rd_count, 0);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_busy", busy, 0);
        m_ready = 1'b1;
        fifo_q.push_back(8'h55); push_exp(8'h55, 1'b0);
        wait_drain();
        repeat (2) step();
        chk("mid_rst_count_restart", rd_count, 1);

        chk("no_underflow", underflow_err, 0);
        chk("valid_hold", hold_err, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain engine for the dual-clock FIFO; lives entirely in the read clock domain.
- Pulls words through the FIFO's r_en/r_empty/r_data port and presents them as a registered valid/ready stream with packet framing (m_last).
- Provides a flush mechanism that discards buffered data and drains the FIFO.
- A 2-entry output buffer decouples m_ready from r_en, so no combinational path exists from the stream side to the FIFO.

Parameters:
- DSIZE, 8, data word width; matches the FIFO DSIZE.
- LSIZE, 8, width of the packet-length configuration and beat counter.
- CSIZE, 16, width of the delivered-word statistics counter.

Ports:
- r_clk  in  1  read-domain clock
- r_rst  in  1  synchronous, active-high reset
- r_empty  in  1  FIFO empty flag
- r_data  in  DSIZE  FIFO read data; asynchronous read, valid in the same cycle while r_empty=0
- r_en  out  1  FIFO read strobe; the pointer advances at the next r_clk edge
- m_valid  out  1  stream data valid
- m_ready  in  1  downstream ready
- m_data  out  DSIZE  stream data
- m_last  out  1  last beat of the current packet
- cfg_len  in  LSIZE  packet length in beats; 0 is treated as 1; sampled on the first beat of each packet
- flush  in  1  single-cycle flush request
- flush_done  out  1  one-cycle pulse when a flush completes
- rd_count  out  CSIZE  count of accepted beats; wraps modulo 2^CSIZE
- busy  out  1  high when the buffer is non-empty or state is FLUSH

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are r_clk and r_rst.
- Reset values:
  - r_en=0, m_valid=0, m_last=0, m_data=0, flush_done=0, rd_count=0, busy=0.
  - Buffer count=0, beat_cnt=0, state=RUN.
  - Reset asserted mid-transfer abandons all buffered data. The FIFO itself is reset separately.
- Buffer: 2-entry FIFO (head/tail registers plus a count of 0..2). m_data/m_valid come from the head entry.
- Fetch (RUN):
  - r_en = !r_empty && (count < 2). This is purely registered state plus r_empty.
  - When r_en=1, r_data is written to the tail at the same edge.
- Pop: occurs when m_valid && m_ready.
- Push and pop may coincide. At count=1 this sustains 1 word/cycle. At count=2 no push occurs (r_en=0) and the pop alone frees a slot.
- Latency: the first word is visible on m_valid one cycle after r_empty falls (r_en cycle plus capture).
- m_valid holds stable, with m_data unchanged, until accepted. Handshake follows AXI-stream rules; the block never drops m_valid without a pop.
- Framing:
  - len_q = max(cfg_len,1) is captured whenever beat_cnt==0 and a pop occurs; that beat uses the new value.
  - m_last = m_valid && (beat_cnt == len_q-1), where the comparison uses the live len_q when beat_cnt==0.
  - On a pop, beat_cnt increments, or clears to 0 when m_last=1.
  - len=1 asserts m_last on every beat.
- rd_count increments on every pop and wraps at 2^CSIZE-1 to 0.
- State machine:
  - RUN: normal operation.
  - flush=1 in RUN causes the following at the next edge:
    - the buffer clears (m_valid=0);
    - beat_cnt is zeroed;
    - state moves to FLUSH;
    - a pop in the same cycle still counts in rd_count.
  - FLUSH: m_valid=0 and r_en=!r_empty; read data is discarded.
  - FLUSH exits to RUN at the edge where r_empty=1 and flush=0, and flush_done pulses for 1 cycle.
  - flush asserted again while in FLUSH extends FLUSH.
- Empty FIFO: r_en is never asserted while r_empty=1, so there is no underflow.
- Full buffer: r_en=0 regardless of r_empty.

Decomposition:
- Shared package (async_fifo_pkg):
  - typedef enum {RUN, FLUSH} rd_state_t;
  - localparam defaults for DSIZE and ASIZE, reused by async_fifo.
- One natural sub-module: stream_skid2. It is the 2-entry buffer with push/pop/clear and count output, parameterised by DSIZE.
- The top level holds the fetch logic, framing counter, FSM and statistics.

Test Plan:
- Reset then idle: r_empty=1 for 20 cycles -> r_en=0 and m_valid=0 throughout; rd_count=0; busy=0.
- Streaming: FIFO preloaded with 0x01..0x10, m_ready=1 constantly -> 16 beats in order on consecutive cycles after 2-cycle startup; rd_count=16; r_en never high while r_empty=1.
- Backpressure: FIFO holds 0xA0..0xA5, m_ready=0 for 10 cycles and then 1 -> r_en fires exactly twice then stalls; m_data holds 0xA0 stable; on release all 6 words arrive in order with no loss or duplication.
- Framing with cfg_len=3 across 7 beats -> m_last on beats 3 and 6. With cfg_len changed to 0 mid-packet, the next packet is 1 beat and m_last is high on every beat.
- Flush: 2 words buffered plus 5 in the FIFO, pulse flush -> m_valid falls next cycle; r_en drains the 5 words; flush_done pulses once when r_empty=1; following traffic starts at beat_cnt=0.
- Reset mid-packet with count=2, then a new preload of 0x55 -> first beat out is 0x55 with m_last computed from beat 0; rd_count restarts at 0.
